// File: rtl/mvu_pe_ctrl_pkg.sv
// Shared definitions for the MVU processing-element controller.
//   mvu_ctrl_state_t : sequencing state (FILL / REUSE / HOLD)
//   clog2_min1       : address-width helper that never returns less than 1
package mvu_pe_ctrl_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,   // first neuron fold: beats come from the input stream
        REUSE = 2'd1,   // later neuron folds: beats come from the activation buffer
        HOLD  = 2'd2    // fold finished, waiting for the result to be taken
    } mvu_ctrl_state_t;

    // A 1-entry memory still needs a 1-bit address port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvu_pe_ctrl_dly.sv
// mvu_ctrl_dly: DEPTH-stage shift register that aligns the issue-stage
// control bits with data arriving from the weight memory / activation buffer.
//   clk   in  clock
//   rst_n in  asynchronous active-low reset, clears every stage
//   d     in  W-bit control word from the issue stage
//   q     out the same word DEPTH cycles later
module mvu_ctrl_dly #(
    parameter int DEPTH = 1,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // chain[0] is the input, chain[gi+1] the output of stage gi
    logic [W-1:0] chain [DEPTH+1];

    assign chain[0] = d;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] q_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q_reg <= '0;
                else        q_reg <= chain[gi];
            end
            assign chain[gi+1] = q_reg;
        end
    endgenerate

    assign q = chain[DEPTH];

endmodule

// File: rtl/mvu_pe_ctrl.sv
// mvu_pe_ctrl: sequencing controller for one MVU PE array. Walks the weight
// matrix in SF synapse folds x NF neuron folds, drives the weight memory and
// activation buffer, times accumulator enable/clear and owns both handshakes.
//   clk, rst_n          clock / asynchronous active-low reset
//   in_v, in_rdy        input activation beat handshake
//   out_v, out_rdy      finished neuron fold handshake
//   wmem_en, wmem_addr  weight-memory read (addr = nf*SF + sf)
//   ibuf_we, ibuf_addr  activation-buffer write / address (= sf)
//   act_sel             0 = streamed activation, 1 = buffer read data
//   acc_en, acc_clr     accumulator update / load-instead-of-add
//   busy                a fold is in progress or a result is pending
module mvu_pe_ctrl
    import mvu_pe_ctrl_pkg::*;
#(
    parameter int MatrixW  = 4,
    parameter int MatrixH  = 4,
    parameter int SIMD     = 2,
    parameter int PE       = 2,
    parameter int WMEM_LAT = 1,
    localparam int SF      = MatrixW / SIMD,
    localparam int NF      = MatrixH / PE,
    localparam int WMEM_AW = clog2_min1(SF * NF),
    localparam int IBUF_AW = clog2_min1(SF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_v,
    output logic               in_rdy,
    output logic               out_v,
    input  logic               out_rdy,
    output logic               wmem_en,
    output logic [WMEM_AW-1:0] wmem_addr,
    output logic               ibuf_we,
    output logic [IBUF_AW-1:0] ibuf_addr,
    output logic               act_sel,
    output logic               acc_en,
    output logic               acc_clr,
    output logic               busy
);

    localparam int NF_W = clog2_min1(NF);

    mvu_ctrl_state_t    state_reg, state_next;
    logic [IBUF_AW-1:0] sf_reg, sf_next;
    logic [NF_W-1:0]    nf_reg, nf_next;
    logic [WMEM_AW-1:0] addr_reg, addr_next;
    logic               pending_reg, pending_next;
    logic               out_v_reg, out_v_next;
    // Low while in reset and for the first edge after it, so in_rdy is 0
    // during reset yet still comes from a register only.
    logic               alive_reg;

    logic               issue;
    logic               sf_last, nf_last, addr_last;
    logic               out_fire;
    logic [3:0]         dly_d, dly_q;
    logic               dly_last;

    assign sf_last   = (sf_reg == IBUF_AW'(SF - 1));
    assign nf_last   = (nf_reg == NF_W'(NF - 1));
    assign addr_last = (addr_reg == WMEM_AW'(SF * NF - 1));
    assign out_fire  = out_v_reg && out_rdy;

    always_comb begin
        in_rdy = alive_reg && (state_reg == FILL) && !pending_reg;
        issue  = 1'b0;
        case (state_reg)
            FILL:    issue = in_v && in_rdy;
            REUSE:   issue = 1'b1;
            default: issue = 1'b0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        sf_next      = sf_reg;
        nf_next      = nf_reg;
        addr_next    = addr_reg;
        pending_next = pending_reg;
        out_v_next   = out_v_reg;

        if (issue) begin
            addr_next = addr_last ? '0 : addr_reg + 1'b1;
            if (sf_last) begin
                sf_next      = '0;
                nf_next      = nf_last ? '0 : nf_reg + 1'b1;
                pending_next = 1'b1;
                state_next   = HOLD;
            end else begin
                sf_next = sf_reg + 1'b1;
            end
        end

        // nf has already wrapped by the time we sit in HOLD
        if (state_reg == HOLD && out_fire)
            state_next = (nf_reg != '0) ? REUSE : FILL;

        if (out_fire) begin
            out_v_next   = 1'b0;
            pending_next = 1'b0;
        end
        // Accumulator absorbs its final beat this cycle; result is valid next.
        if (acc_en && dly_last)
            out_v_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= FILL;
            sf_reg      <= '0;
            nf_reg      <= '0;
            addr_reg    <= '0;
            pending_reg <= 1'b0;
            out_v_reg   <= 1'b0;
            alive_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sf_reg      <= sf_next;
            nf_reg      <= nf_next;
            addr_reg    <= addr_next;
            pending_reg <= pending_next;
            out_v_reg   <= out_v_next;
            alive_reg   <= 1'b1;
        end
    end

    // clr/sel/last are qualified by issue so idle cycles carry all zeros.
    assign dly_d = {issue,
                    issue && (sf_reg == '0),
                    issue && (nf_reg != '0),
                    issue && sf_last};

    mvu_ctrl_dly #(
        .DEPTH (WMEM_LAT),
        .W     (4)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dly_d),
        .q     (dly_q)
    );

    assign acc_en    = dly_q[3];
    assign acc_clr   = dly_q[2];
    assign act_sel   = dly_q[1];
    assign dly_last  = dly_q[0];

    assign out_v     = out_v_reg;
    assign wmem_en   = issue;
    assign wmem_addr = addr_reg;
    assign ibuf_we   = issue && (state_reg == FILL);
    assign ibuf_addr = sf_reg;
    assign busy      = (state_reg != FILL) || (sf_reg != '0) || pending_reg;

endmodule

// File: tb/tb_mvu_pe_ctrl.sv
// Directed testbench for mvu_pe_ctrl.
//   Instance A: SF=4, NF=2, WMEM_LAT=1 (reset/idle, full vector, bubbles,
//               backpressure, reset mid-fold).
//   Instance B: SF=1, NF=1, WMEM_LAT=2 (degenerate single-beat folds).
// Observed/expected vectors are packed as
//   {in_rdy,out_v,wmem_en,wmem_addr,ibuf_we,ibuf_addr,act_sel,acc_en,acc_clr,busy}
module tb_mvu_pe_ctrl;

    logic clk;
    logic rst_n;

    logic       a_in_v, a_in_rdy, a_out_v, a_out_rdy, a_wmem_en, a_ibuf_we;
    logic [2:0] a_wmem_addr;
    logic [1:0] a_ibuf_addr;
    logic       a_act_sel, a_acc_en, a_acc_clr, a_busy;

    logic       b_in_v, b_in_rdy, b_out_v, b_out_rdy, b_wmem_en, b_ibuf_we;
    logic [0:0] b_wmem_addr;
    logic [0:0] b_ibuf_addr;
    logic       b_act_sel, b_acc_en, b_acc_clr, b_busy;

    int total = 0;
    int bad   = 0;

    mvu_pe_ctrl #(
        .MatrixW(8), .MatrixH(4), .SIMD(2), .PE(2), .WMEM_LAT(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_v(a_in_v), .in_rdy(a_in_rdy),
        .out_v(a_out_v), .out_rdy(a_out_rdy),
        .wmem_en(a_wmem_en), .wmem_addr(a_wmem_addr),
        .ibuf_we(a_ibuf_we), .ibuf_addr(a_ibuf_addr),
        .act_sel(a_act_sel), .acc_en(a_acc_en), .acc_clr(a_acc_clr),
        .busy(a_busy)
    );

    mvu_pe_ctrl #(
        .MatrixW(2), .MatrixH(2), .SIMD(2), .PE(2), .WMEM_LAT(2)
    ) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_v(b_in_v), .in_rdy(b_in_rdy),
        .out_v(b_out_v), .out_rdy(b_out_rdy),
        .wmem_en(b_wmem_en), .wmem_addr(b_wmem_addr),
        .ibuf_we(b_ibuf_we), .ibuf_addr(b_ibuf_addr),
        .act_sel(b_act_sel), .acc_en(b_acc_en), .acc_clr(b_acc_clr),
        .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One line per accepted result.
    always @(posedge clk) begin
        if (a_out_v && a_out_rdy) $display("tb: A result accepted at %0t", $time);
        if (b_out_v && b_out_rdy) $display("tb: B result accepted at %0t", $time);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic ir, input logic ov, input logic we,
                         input logic [2:0] wa, input logic iw, input logic [1:0] ia,
                         input logic sel, input logic en, input logic clr, input logic bsy);
        logic [12:0] exp_v, obs_v;
        exp_v = {ir, ov, we, wa, iw, ia, sel, en, clr, bsy};
        obs_v = {a_in_rdy, a_out_v, a_wmem_en, a_wmem_addr, a_ibuf_we, a_ibuf_addr,
                 a_act_sel, a_acc_en, a_acc_clr, a_busy};
        total++;
        assert (obs_v === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs_v, exp_v);
        end
    endtask

    task automatic chk_b(input string tag, input logic ir, input logic ov, input logic we,
                         input logic wa, input logic iw, input logic ia,
                         input logic sel, input logic en, input logic clr, input logic bsy);
        logic [9:0] exp_v, obs_v;
        exp_v = {ir, ov, we, wa, iw, ia, sel, en, clr, bsy};
        obs_v = {b_in_rdy, b_out_v, b_wmem_en, b_wmem_addr, b_ibuf_we, b_ibuf_addr,
                 b_act_sel, b_acc_en, b_acc_clr, b_busy};
        total++;
        assert (obs_v === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs_v, exp_v);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_v = 1'b0; a_out_rdy = 1'b1;
        b_in_v = 1'b0; b_out_rdy = 1'b1;

        // ---------------- reset / idle ----------------
        #12;
        chk_a("a_in_reset", 0,0,0,3'd0,0,2'd0,0,0,0,0);
        chk_b("b_in_reset", 0,0,0,1'b0,0,1'b0,0,0,0,0);
        #10 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1 chk_a("a_idle", 1,0,0,3'd0,0,2'd0,0,0,0,0);
            tick();
        end
        #1 chk_b("b_idle", 1,0,0,1'b0,0,1'b0,0,0,0,0);

        // ---------------- full vector, out_rdy high ----------------
        a_in_v = 1'b1;
        #1 chk_a("full_c0", 1,0,1,3'd0,1,2'd0,0,0,0,0); tick();
        #1 chk_a("full_c1", 1,0,1,3'd1,1,2'd1,0,1,1,1); tick();
        #1 chk_a("full_c2", 1,0,1,3'd2,1,2'd2,0,1,0,1); tick();
        #1 chk_a("full_c3", 1,0,1,3'd3,1,2'd3,0,1,0,1); tick();
        a_in_v = 1'b0;
        #1 chk_a("full_c4", 0,0,0,3'd4,0,2'd0,0,1,0,1); tick();
        #1 chk_a("full_c5", 0,1,0,3'd4,0,2'd0,0,0,0,1); tick();
        #1 chk_a("full_c6", 0,0,1,3'd4,0,2'd0,0,0,0,1); tick();
        #1 chk_a("full_c7", 0,0,1,3'd5,0,2'd1,1,1,1,1); tick();
        #1 chk_a("full_c8", 0,0,1,3'd6,0,2'd2,1,1,0,1); tick();
        #1 chk_a("full_c9", 0,0,1,3'd7,0,2'd3,1,1,0,1); tick();
        #1 chk_a("full_c10", 0,0,0,3'd0,0,2'd0,1,1,0,1); tick();
        #1 chk_a("full_c11", 0,1,0,3'd0,0,2'd0,0,0,0,1); tick();
        #1 chk_a("full_c12", 1,0,0,3'd0,0,2'd0,0,0,0,0); tick();

        // ---------------- bubbles, then backpressure ----------------
        a_in_v = 1'b1;
        #1 chk_a("bub_d0", 1,0,1,3'd0,1,2'd0,0,0,0,0); tick();
        a_in_v = 1'b0;
        #1 chk_a("bub_d1", 1,0,0,3'd1,0,2'd1,0,1,1,1); tick();
        a_in_v = 1'b1;
        #1 chk_a("bub_d2", 1,0,1,3'd1,1,2'd1,0,0,0,1); tick();
        a_in_v = 1'b0;
        #1 chk_a("bub_d3", 1,0,0,3'd2,0,2'd2,0,1,0,1); tick();
        a_in_v = 1'b1;
        #1 chk_a("bub_d4", 1,0,1,3'd2,1,2'd2,0,0,0,1); tick();
        a_in_v = 1'b0;
        #1 chk_a("bub_d5", 1,0,0,3'd3,0,2'd3,0,1,0,1); tick();
        a_in_v = 1'b1;
        #1 chk_a("bub_d6", 1,0,1,3'd3,1,2'd3,0,0,0,1); tick();
        a_in_v = 1'b1;   // held high: must be ignored while not ready
        a_out_rdy = 1'b0;
        #1 chk_a("bp_d7", 0,0,0,3'd4,0,2'd0,0,1,0,1); tick();
        for (int i = 0; i < 10; i++) begin
            #1 chk_a("bp_hold", 0,1,0,3'd4,0,2'd0,0,0,0,1);
            tick();
        end
        a_out_rdy = 1'b1;
        #1 chk_a("bp_fire", 0,1,0,3'd4,0,2'd0,0,0,0,1); tick();
        a_in_v = 1'b0;
        #1 chk_a("bp_after", 0,0,1,3'd4,0,2'd0,0,0,0,1); tick();

        // ---------------- asynchronous reset mid-fold ----------------
        #1 chk_a("mid_pre", 0,0,1,3'd5,0,2'd1,1,1,1,1);
        #1 rst_n = 1'b0;
        #1 chk_a("mid_async", 0,0,0,3'd0,0,2'd0,0,0,0,0);
        tick();
        rst_n = 1'b1;
        tick();
        a_in_v = 1'b1;
        #1 chk_a("mid_first", 1,0,1,3'd0,1,2'd0,0,0,0,0); tick();
        a_in_v = 1'b0;
        #1 chk_a("mid_clr", 1,0,0,3'd1,0,2'd1,0,1,1,1); tick();

        // ---------------- degenerate SF=1 NF=1 LAT=2 ----------------
        b_in_v = 1'b1;
        b_out_rdy = 1'b0;
        #1 chk_b("deg_b0", 1,0,1,1'b0,1,1'b0,0,0,0,0); tick();
        b_in_v = 1'b1;   // must be ignored until the handshake
        #1 chk_b("deg_b1", 0,0,0,1'b0,0,1'b0,0,0,0,1); tick();
        #1 chk_b("deg_b2", 0,0,0,1'b0,0,1'b0,0,1,1,1); tick();
        #1 chk_b("deg_b3", 0,1,0,1'b0,0,1'b0,0,0,0,1); tick();
        b_out_rdy = 1'b1;
        #1 chk_b("deg_b4", 0,1,0,1'b0,0,1'b0,0,0,0,1); tick();
        #1 chk_b("deg_b5", 1,0,1,1'b0,1,1'b0,0,0,0,0); tick();
        b_in_v = 1'b0;
        #1 chk_b("deg_b6", 0,0,0,1'b0,0,1'b0,0,0,0,1); tick();
        #1 chk_b("deg_b7", 0,0,0,1'b0,0,1'b0,0,1,1,1); tick();
        #1 chk_b("deg_b8", 0,1,0,1'b0,0,1'b0,0,0,0,1); tick();
        #1 chk_b("deg_b9", 1,0,0,1'b0,0,1'b0,0,0,0,0); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
